uart_receiver: RTL

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 39 +++
 rtl/sync_ff.sv | 25 ++
 rtl/uart_receiver.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receiver: FSM state codes, data-width and parity encodings,
// and the per-frame configuration latched at start detection.
package uart_pkg;

    // FSM state codes
    typedef logic [2:0] rx_state_t;
    localparam rx_state_t StIdle   = 3'd0;
    localparam rx_state_t StStart  = 3'd1;
    localparam rx_state_t StData   = 3'd2;
    localparam rx_state_t StParity = 3'd3;
    localparam rx_state_t StStop   = 3'd4;

    // data_width_i encoding: number of data bits is 5 + code
    typedef enum logic [1:0] {
        Width5 = 2'b00,
        Width6 = 2'b01,
        Width7 = 2'b10,
        Width8 = 2'b11
    } data_width_e;

    typedef enum logic {
        ParityEven = 1'b0,
        ParityOdd  = 1'b1
    } parity_mode_e;

    // Frame format, frozen for the duration of one frame
    typedef struct packed {
        data_width_e  width;
        logic         parity_en;
        parity_mode_e parity_mode;
        logic         two_stop;
    } rx_cfg_t;

    // Index of the last data bit for a given width code
    function automatic logic [2:0] last_bit_idx(data_width_e w);
        return 3'd4 + {1'b0, w};
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input; resets to 1 so an idle-high
// line is not mistaken for a start bit when reset releases.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the input through the flop chain
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled, 5-8 data bits, optional parity, 1 or 2 stop bits.
// Holds one received frame for the consumer and flags overrun when it is overwritten.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ov_baud_rt_i,
    input  logic       rx_i,
    input  logic [1:0] data_width_i,
    input  logic       parity_en_i,
    input  logic       parity_odd_i,
    input  logic       stop_bits_i,
    input  logic       data_read_i,
    output logic [7:0] data_o,
    output logic       rx_valid_o,
    output logic       parity_err_o,
    output logic       frame_err_o,
    output logic       overrun_err_o,
    output logic       rx_busy_o
);

    logic       rx_s;
    rx_state_t  state_q, state_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    rx_cfg_t    cfg_q, cfg_d;
    logic       frame_bad_q, frame_bad_d;
    logic       par_bad_q, par_bad_d;
    logic       deliver;

    logic [7:0] data_q;
    logic       valid_q, perr_q, ferr_q, ovr_q;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .d_i     (rx_i),
        .q_o     (rx_s)
    );

    // Frame FSM: bit timing advances only on oversample ticks
    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cfg_d       = cfg_q;
        frame_bad_d = frame_bad_q;
        par_bad_d   = par_bad_q;
        deliver     = 1'b0;
        if (ov_baud_rt_i) begin
            tick_cnt_d = tick_cnt_q + 4'd1;
            case (state_q)
                StIdle: begin
                    tick_cnt_d = '0;
                    if (!rx_s) begin
                        state_d               = StStart;
                        bit_cnt_d             = '0;
                        shift_d               = '0;
                        frame_bad_d           = 1'b0;
                        par_bad_d             = 1'b0;
                        cfg_d.width           = data_width_e'(data_width_i);
                        cfg_d.parity_en       = parity_en_i;
                        cfg_d.parity_mode     = parity_mode_e'(parity_odd_i);
                        cfg_d.two_stop        = stop_bits_i;
                    end
                end
                StStart: begin
                    // Mid start bit: a high line here was a glitch, not a start
                    if (tick_cnt_q == 4'd7) begin
                        tick_cnt_d = '0;
                        state_d    = rx_s ? StIdle : StData;
                    end
                end
                StData: begin
                    if (tick_cnt_q == 4'd15) begin
                        shift_d[bit_cnt_q] = rx_s;
                        if (bit_cnt_q == last_bit_idx(cfg_q.width)) begin
                            bit_cnt_d = '0;
                            state_d   = cfg_q.parity_en ? StParity : StStop;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                StParity: begin
                    if (tick_cnt_q == 4'd15) begin
                        par_bad_d = (^shift_q) ^ rx_s ^ (cfg_q.parity_mode == ParityOdd);
                        state_d   = StStop;
                    end
                end
                StStop: begin
                    if (tick_cnt_q == 4'd15) begin
                        if (!rx_s) begin
                            frame_bad_d = 1'b1;
                        end
                        if (bit_cnt_q == {2'b00, cfg_q.two_stop}) begin
                            deliver   = 1'b1;
                            bit_cnt_d = '0;
                            state_d   = StIdle;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Frame FSM state and datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            cfg_q       <= '0;
            frame_bad_q <= 1'b0;
            par_bad_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cfg_q       <= cfg_d;
            frame_bad_q <= frame_bad_d;
            par_bad_q   <= par_bad_d;
        end
    end

    // Holding register and consumer handshake; overrun only when unread data is lost
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (deliver) begin
                data_q  <= shift_q;
                perr_q  <= par_bad_q;
                ferr_q  <= frame_bad_d;
                valid_q <= 1'b1;
            end else if (data_read_i && valid_q) begin
                valid_q <= 1'b0;
            end
            if (deliver && valid_q && !data_read_i) begin
                ovr_q <= 1'b1;
            end else if (data_read_i && valid_q) begin
                ovr_q <= 1'b0;
            end
        end
    end

    assign data_o        = data_q;
    assign rx_valid_o    = valid_q;
    assign parity_err_o  = perr_q;
    assign frame_err_o   = ferr_q;
    assign overrun_err_o = ovr_q;
    assign rx_busy_o     = (state_q != StIdle);

endmodule
